// File: rtl/seq_generator_pkg.sv
// Shared constants for the Padovan-type sequence generator:
// default data width and the three seed terms a(0), a(1), a(2).
package seq_generator_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam int unsigned SEED0 = 0;
  localparam int unsigned SEED1 = 1;
  localparam int unsigned SEED2 = 1;

endpackage : seq_generator_pkg

// File: rtl/seq_generator_if.sv
// Carries the generated sequence term between the generator side (master)
// and any consumer or monitor (slave).
interface seq_generator_if
  import seq_generator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic clk
);

  logic [WIDTH-1:0] seq;

  modport master (input clk, output seq);
  modport slave  (input clk, input seq);

endinterface : seq_generator_if

// File: rtl/seq_generator.sv
// Free-running generator of a(n) = a(n-2) + a(n-3) modulo 2^WIDTH,
// seeded (0, 1, 1); the output is the newest term, straight from a register.
module seq_generator
  import seq_generator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] seq_o
);

  logic [WIDTH-1:0] r_t0;
  logic [WIDTH-1:0] r_t1;
  logic [WIDTH-1:0] r_t2;
  logic [WIDTH-1:0] w_sum;

  // Truncating add: wrap-around is intended and feeds back into the recurrence.
  assign w_sum = r_t0 + r_t1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_t0 <= WIDTH'(SEED0);
      r_t1 <= WIDTH'(SEED1);
      r_t2 <= WIDTH'(SEED2);
    end else begin
      r_t0 <= r_t1;
      r_t1 <= r_t2;
      r_t2 <= w_sum;
    end
  end

  assign seq_o = r_t2;

endmodule : seq_generator

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator at WIDTH=32 and WIDTH=8, compared
// against the sequence a(n) computed directly from its definition.
module tb_seq_generator;

  localparam int NTERMS = 260;

  logic       clk;
  logic       reset;
  logic [7:0] seq8;

  int checks;
  int failures;

  longint unsigned refA [NTERMS];

  seq_generator_if #(.WIDTH(32)) monIf (.clk(clk));

  seq_generator #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .seq_o (monIf.seq)
  );

  seq_generator #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .seq_o (seq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a(n) from the definition using 64-bit wrapping arithmetic; any lower
  // width is then just the low bits, since 2^WIDTH divides 2^64.
  task automatic build_model();
    refA[0] = 0;
    refA[1] = 1;
    refA[2] = 1;
    for (int n = 3; n < NTERMS; n++) refA[n] = refA[n-2] + refA[n-3];
  endtask

  // Reset held across edges: output stays at the seed and the older terms never move.
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      checks++;
      if (monIf.seq !== 32'd1) begin
        failures++;
        $display("[TB] FAIL reset_seq32 edge %0d: got %0d expected 1", e, monIf.seq);
      end
      checks++;
      if (dut32.r_t0 !== 32'd0 || dut32.r_t1 !== 32'd1) begin
        failures++;
        $display("[TB] FAIL reset_t0t1 edge %0d: got t0=%0d t1=%0d expected t0=0 t1=1",
                 e, dut32.r_t0, dut32.r_t1);
      end
      checks++;
      if (seq8 !== 8'd1) begin
        failures++;
        $display("[TB] FAIL reset_seq8 edge %0d: got %0d expected 1", e, seq8);
      end
    end
  endtask

  // Release between edges and sample just before each rising edge.
  task automatic test_sequence();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      #4;
      checks++;
      if (monIf.seq !== refA[2+k][31:0]) begin
        failures++;
        $display("[TB] FAIL seq_start a(%0d): got %0d expected %0d", 2+k, monIf.seq, refA[2+k][31:0]);
      end
      @(negedge clk);
    end
  endtask

  // Asynchronous reset between edges after a number of clocks, then restart.
  task automatic test_midreset(input int runClocks, input int holdClocks);
    int dly;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (runClocks) @(posedge clk);
    dly = int'($urandom_range(1, 3));
    #(dly);
    reset = 1'b1;
    #1;
    checks++;
    if (monIf.seq !== 32'd1 || seq8 !== 8'd1) begin
      failures++;
      $display("[TB] FAIL midreset_async after %0d clocks: got %0d/%0d expected 1/1",
               runClocks, monIf.seq, seq8);
    end
    repeat (holdClocks) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (monIf.seq !== refA[2+k][31:0]) begin
        failures++;
        $display("[TB] FAIL midreset_restart a(%0d): got %0d expected %0d", 2+k, monIf.seq, refA[2+k][31:0]);
      end
      @(negedge clk);
    end
  endtask

  // 8-bit instance past the first overflow: a(22)=265 must read as 9.
  task automatic test_wrap8();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      checks++;
      if (seq8 !== refA[2+k][7:0]) begin
        failures++;
        $display("[TB] FAIL wrap8 a(%0d): got %0d expected %0d", 2+k, seq8, refA[2+k][7:0]);
      end
      if (k == 20) begin
        checks++;
        if (seq8 !== 8'd9) begin
          failures++;
          $display("[TB] FAIL wrap8_a22: got %0d expected 9", seq8);
        end
      end
      @(negedge clk);
    end
  endtask

  // 200 terms at 32 bits, including well past 32-bit overflow.
  task automatic test_long32();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      checks++;
      if ($isunknown(monIf.seq) || monIf.seq !== refA[2+k][31:0]) begin
        failures++;
        $display("[TB] FAIL long32 a(%0d): got %0h expected %0h", 2+k, monIf.seq, refA[2+k][31:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    build_model();
    test_reset();
    test_sequence();
    test_midreset(13, 2);
    for (int t = 0; t < 4; t++)
      test_midreset(int'($urandom_range(1, 40)), int'($urandom_range(1, 4)));
    test_wrap8();
    test_long32();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule : tb_seq_generator

// File: doc/seq_generator.md
SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 The block SHALL have one clock and one asynchronous, active-high reset.
REQ-002 Parameter: WIDTH, default 32, data width of the output and all internal terms.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  asynchronous, active-high reset; forces the seed state immediately.
REQ-005 Port: seq_o  output  WIDTH  current sequence term, driven directly from a register.

Function
REQ-006 The block SHALL generate the Padovan-type recurrence a(n) = a(n-2) + a(n-3), seeded a(0)=0, a(1)=1, a(2)=1.
REQ-007 Internal state SHALL be three WIDTH-bit registers t0, t1, t2, where t2 is the newest term; seq_o SHALL equal t2.
REQ-008 Reset state: t0=0, t1=1, t2=1, so seq_o=1 while reset is asserted.
REQ-009 On each rising clk edge with reset low: t0<=t1, t1<=t2, t2<=t0+t1, all updated together.
REQ-010 The output SHALL advance one term per clock with no stall, enable or handshake.
REQ-011 Output order from reset: 1 (reset value), 1, 2, 2, 3, 4, 5, 7, 9, 12, 16, 21, 28, 37, 49, 65, ...
REQ-012 Addition SHALL be modulo 2^WIDTH; overflow SHALL wrap silently, with no saturation and no flag.
REQ-013 The recurrence SHALL keep running after wrap-around, using the truncated values.
REQ-014 There SHALL be no combinational path from any input to seq_o.

Reset
REQ-015 Asserting reset at any time, including mid-sequence, SHALL restore (0,1,1) immediately, without waiting for a clock edge.
REQ-016 While reset is high, clock edges SHALL have no effect.
REQ-017 After reset is deasserted, the first rising edge SHALL load t2=1 (0+1).
REQ-018 Reset deassertion need not be synchronised inside the block; the integrator provides a deassertion that meets the clock's recovery and removal timing.

Structure
REQ-019 A shared package SHALL hold the default WIDTH and the seed constants SEED0=0, SEED1=1, SEED2=1.
REQ-020 The block SHALL be a single module with no sub-module; it is one always_ff state update plus a single adder.

Verification
REQ-021 Hold reset high across several edges -> seq_o stays 1, and t0/t1 show no change.
REQ-022 Release reset between edges, then sample seq_o just before each subsequent rising edge -> 1, 1, 2, 2, 3, 4, 5, 7, 9, 12, 16, 21, 28, 37.
REQ-023 Run 13 clocks after release, then assert reset asynchronously between edges -> seq_o returns to 1 before the next edge; after release the sequence restarts 1, 2, 2, 3.
REQ-024 Run with WIDTH=8 until the true value exceeds 255 -> term a(n)=265 reads as 9, and later terms continue as (a(n-2)+a(n-3)) mod 256.
REQ-025 Run 200 cycles at WIDTH=32 against a reference model of the recurrence -> every term matches mod 2^32, with no X/Z on seq_o after reset.
